// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding request, one-entry skid
// buffer, delayed-branch redirect handling with wrong-path kill.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        pc_align_err
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {IDLE, BUSY, SKID} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        im_req_q, im_req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        kill_q, kill_d;
  logic        align_err_q, align_err_d;

  logic [31:0] tgt;
  logic [31:0] nxt;

  always_comb begin
    tgt          = {redir_pc[31:2], 2'b00};
    nxt          = pend_q ? pend_pc_q : pc_q + 32'd4;
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    kill_d       = kill_q;
    align_err_d  = redir_valid && (redir_pc[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        state_d = BUSY;
        if (!stall) if_valid_d = 1'b0;
      end
      BUSY: begin
        if (redir_valid && if_valid_q) begin
          // Delay slot is leaving if_* now, so the outstanding fetch is wrong-path.
          if_valid_d = 1'b0;
          if (im_ack) begin
            pc_d   = tgt;
            pend_d = 1'b0;
            kill_d = 1'b0;
          end else begin
            pend_d    = 1'b1;
            pend_pc_d = tgt;
            kill_d    = 1'b1;
          end
        end else if (im_ack && kill_q) begin
          pc_d   = redir_valid ? tgt : nxt;
          pend_d = 1'b0;
          kill_d = 1'b0;
          if (!stall) if_valid_d = 1'b0;
        end else if (im_ack) begin
          if (!if_valid_q || !stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = im_rdata;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = im_rdata;
            state_d      = SKID;
          end
          pc_d   = redir_valid ? tgt : nxt;
          pend_d = 1'b0;
        end else begin
          if (redir_valid) begin
            pend_d    = 1'b1;
            pend_pc_d = tgt;
          end
          if (!stall) if_valid_d = 1'b0;
        end
      end
      SKID: begin
        if (redir_valid) begin
          if_valid_d = 1'b0;
          pc_d       = tgt;
          pend_d     = 1'b0;
          kill_d     = 1'b0;
          state_d    = BUSY;
        end else if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          state_d    = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    im_req_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      im_req_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      kill_q       <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      im_req_q     <= im_req_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      kill_q       <= kill_d;
      align_err_q  <= align_err_d;
    end
  end

  assign im_req       = im_req_q;
  assign im_addr      = pc_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign pc_align_err = align_err_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low; all state cleared while 0.
REQ-003 SHALL have: stall  input  1  IF/ID hold from hazard unit; delivered instruction not consumed while 1.
REQ-004 SHALL have: redir_valid  input  1  one-cycle pulse from ID for a taken branch/jump; only asserted when stall=0.
REQ-005 SHALL have: redir_pc  input  32  target address qualified by redir_valid.
REQ-006 SHALL have: im_req  output  1  instruction-memory request.
REQ-007 SHALL have: im_addr  output  32  fetch address, word aligned.
REQ-008 SHALL have: im_ack  input  1  memory completion; may arrive in the request cycle (zero wait).
REQ-009 SHALL have: im_rdata  input  32  instruction, valid with im_ack.
REQ-010 SHALL have: if_valid, if_pc[31:0], if_instr[31:0]  outputs  fetched instruction to IF/ID.
REQ-011 SHALL have: pc_align_err  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-012 SHALL hold a PC register (next fetch address) and a 3-state FSM: IDLE, BUSY, SKID.
REQ-013 IDLE: im_req=0; SHALL go to BUSY on the first clock after reset release.
REQ-014 BUSY: im_req=1, im_addr=PC; im_req and im_addr SHALL stay stable until im_ack.
REQ-015 BUSY with im_ack and (if_valid=0 or stall=0): SHALL load if_pc<=PC, if_instr<=im_rdata, if_valid<=1, advance PC, remain BUSY (one instruction per cycle at zero wait).
REQ-016 BUSY with im_ack, if_valid=1, stall=1: SHALL capture PC/im_rdata into a one-entry skid buffer, advance PC, go to SKID.
REQ-017 SKID: im_req=0; outputs held; when stall=0 SHALL move skid into if_* outputs and go to BUSY.
REQ-018 No im_ack and stall=0 SHALL clear if_valid (slot consumed, nothing new).
REQ-019 PC advance SHALL select: pending redirect target if set (then clear it), else PC+4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-020 Delay-slot rule: the instruction after a branch SHALL always be delivered; the next one SHALL come from redir_pc.
REQ-021 redir_valid with if_valid=0 (delay slot in flight): SHALL record pending target; in-flight fetch delivered normally.
REQ-022 redir_valid with if_valid=1 and BUSY (wrong-path fetch outstanding): SHALL set kill flag; the matching im_ack is discarded (no delivery), PC<=target; kill cleared on that ack.
REQ-023 redir_valid with if_valid=1 and ack in same cycle: that ack SHALL be discarded, PC<=target.
REQ-024 redir_valid in SKID: skid contents SHALL be discarded, PC<=target, go to BUSY.
REQ-025 redir_pc[1:0]!=0: SHALL pulse pc_align_err next cycle and use redir_pc with bits [1:0] cleared.
REQ-026 A second redir_valid before a pending one is applied SHALL overwrite it.
REQ-027 Outputs SHALL be registered; no combinational path from im_rdata to if_instr.

Reset
REQ-028 On reset=0: state=IDLE, PC=0x00003000, im_req=0, im_addr=0x00003000, if_valid=0, if_pc=0, if_instr=0, pending/kill/skid cleared, pc_align_err=0.
REQ-029 Reset mid-handshake SHALL abandon the outstanding request; an im_ack during reset SHALL be ignored.

Verification
REQ-030 Zero-wait, no stall: reset release -> im_addr 0x3000,0x3004,0x3008 on consecutive cycles; if_pc follows one cycle later with if_valid=1.
REQ-031 3-cycle ack latency: im_addr=0x3004 held stable 3 cycles; if_valid=0 meanwhile, then 1 with if_pc=0x3004.
REQ-032 stall=1 for 4 cycles while if_pc=0x3008 and fetch of 0x300C acks -> SKID entered, if_pc stays 0x3008, then 0x300C on stall drop; no instruction lost/duplicated.
REQ-033 Branch at 0x3010 redirects to 0x3100 with delay slot 0x3014 in flight -> delivered sequence 0x3014, 0x3100; 0x3018 never delivered.
REQ-034 Redirect with delay slot already in if_* and 0x3018 outstanding -> 0x3018 ack discarded, next if_pc=0x3100; redir_pc=0x3102 -> pc_align_err pulse, fetch 0x3100.
REQ-035 Assert reset during BUSY with im_addr=0x3020 -> im_req=0, if_valid=0 immediately; after release first fetch at 0x3000.
